// File: rtl/mem_access_unit.sv
// mem_access_unit
//   CPU-side initiator for the data memory. Takes one load/store at a time,
//   drives MemRead/MemWrite/mem_addr/mem_din, sizes and extends load data,
//   and performs byte/half stores as read-modify-write on the word memory.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     request handshake (ready only in IDLE, rst low)
//   req_write, req_size       store/load, 00 byte 01 half 10 word 11 reserved
//   req_unsigned              load zero-extend (1) / sign-extend (0)
//   req_addr, req_wdata       byte address, store data (low bits for sub-word)
//   resp_valid                one-cycle completion pulse
//   resp_rdata, resp_err      load result / misaligned-or-reserved flag
//   MemRead, MemWrite         memory enables (never both high)
//   mem_addr, mem_din         word address, write data
//   mem_dout                  read data, valid RD_LAT cycles into a read
module mem_access_unit #(
    parameter int unsigned RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            write_q, write_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [31:0]     addr_q, addr_d;
    logic            err_q, err_d;
    // Holds store data from accept until the merge, then the merged word
    // (RMW) or the extracted load result.
    logic [31:0]     data_q, data_d;

    logic            misaligned;

    function automatic logic [31:0] extract(input logic [31:0] w,
                                            input logic [1:0]  a,
                                            input logic [1:0]  sz,
                                            input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: extract = w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w,
                                          input logic [1:0]  a,
                                          input logic [1:0]  sz,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            r[{a, 3'b000} +: 8] = wd[7:0];
        end else if (a[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        merge = r;
    endfunction

    assign misaligned = (req_size == 2'b11)
                     || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    err_d   = misaligned;
                    data_d  = req_wdata;
                    cnt_d   = '0;
                    if (misaligned) begin
                        state_d = RESP;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (cnt_q == CW'(RD_LAT)) begin
                    if (write_q) begin
                        data_d  = merge(mem_dout, addr_q[1:0], size_q, data_q);
                        state_d = WRITE;
                    end else begin
                        data_d  = extract(mem_dout, addr_q[1:0], size_q, uns_q);
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign MemRead    = (state_q == READ);
    assign MemWrite   = (state_q == WRITE);
    assign mem_addr   = (MemRead || MemWrite) ? {2'b00, addr_q[31:2]} : '0;
    assign mem_din    = MemWrite ? data_q : '0;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !write_q) ? data_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a latency-accurate word memory
//   model and a scoreboard of expected responses.
module tb_mem_access_unit;

    localparam int unsigned RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    mem_access_unit #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory model: data appears only after MemRead has been held RD_LAT cycles.
    logic [31:0] mem [0:255];
    logic        load_mem;
    int unsigned rd_run;
    int unsigned wr_total;

    always @(posedge clk) begin
        if (load_mem) begin
            mem[16] <= 32'h876543A1;
            mem[17] <= 32'h0;
        end else if (MemWrite) begin
            mem[mem_addr[7:0]] <= mem_din;
        end
        rd_run   <= (MemRead && !rst) ? rd_run + 1 : 0;
        wr_total <= MemWrite ? wr_total + 1 : wr_total;
    end

    assign mem_dout = (MemRead && rd_run >= RD_LAT) ? mem[mem_addr[7:0]] : 32'hDEAD0BAD;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input string name, input logic w, input logic [1:0] sz,
                           input logic u, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input int unsigned exp_lat, input int unsigned exp_nrd,
                           input int unsigned exp_nwr, input logic [31:0] exp_maddr,
                           input logic [31:0] exp_din);
        exp_t        e;
        exp_t        got;
        int unsigned nrd = 0;
        int unsigned nwr = 0;
        bit          done = 0;
        bit          both = 0;
        logic [31:0] seen_addr = exp_maddr;
        logic [31:0] seen_din  = exp_din;
        @(negedge clk);
        chk({name, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        // Scramble the request lines to show they are ignored after accept.
        req_valid    = 1'b0;
        req_write    = ~w;
        req_size     = ~sz;
        req_unsigned = ~u;
        req_addr     = $urandom;
        req_wdata    = $urandom;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (MemRead) nrd++;
            if (MemWrite) nwr++;
            if (MemRead && MemWrite) both = 1;
            if ((MemRead || MemWrite) && mem_addr !== exp_maddr) seen_addr = mem_addr;
            if (MemWrite && mem_din !== exp_din) seen_din = mem_din;
            if (resp_valid) begin
                done = 1;
                got  = sb.pop_front();
                chk({name, " resp_rdata"}, resp_rdata, got.rdata);
                chk({name, " resp_err"}, 32'(resp_err), 32'(got.err));
                chk({name, " latency"}, 32'(k), 32'(got.lat));
            end
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL %s resp_timeout: observed no resp_valid expected resp within 20 cycles", name);
        end
        chk({name, " MemRead_cycles"}, nrd, exp_nrd);
        chk({name, " MemWrite_cycles"}, nwr, exp_nwr);
        chk({name, " rd_wr_overlap"}, 32'(both), 32'd0);
        chk({name, " mem_addr"}, seen_addr, exp_maddr);
        chk({name, " mem_din"}, seen_din, exp_din);
        if (done) begin
            @(negedge clk);
            chk({name, " resp_pulse"}, 32'(resp_valid), 32'd0);
            chk({name, " idle_mem_addr"}, mem_addr, 32'd0);
        end
    endtask

    initial begin
        int unsigned wr_before;
        rst          = 1'b1;
        load_mem     = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd0);
        chk("rst MemRead", 32'(MemRead), 32'd0);
        chk("rst MemWrite", 32'(MemWrite), 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        load_mem = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rel req_ready", 32'(req_ready), 32'd1);

        // name, w, size, uns, addr, wdata, rdata, err, lat, nrd, nwr, maddr, din
        run_req("ldb_s40", 0, 2'b00, 0, 32'h40, 32'h0, 32'hFFFFFFA1, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("ldh_u42", 0, 2'b01, 1, 32'h42, 32'h0, 32'h00008765, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("ldh_s42", 0, 2'b01, 0, 32'h42, 32'h0, 32'hFFFF8765, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("ldw_40",  0, 2'b10, 0, 32'h40, 32'h0, 32'h876543A1, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("ldb_u43", 0, 2'b00, 1, 32'h43, 32'h0, 32'h00000087, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("ldh_s40", 0, 2'b01, 0, 32'h40, 32'h0, 32'h000043A1, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("stb_41",  1, 2'b00, 0, 32'h41, 32'hFFFFFF5C, 32'h0, 0, 5, 3, 1, 32'h10, 32'h87655CA1);
        run_req("ldw_40b", 0, 2'b10, 0, 32'h40, 32'h0, 32'h87655CA1, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("sth_42",  1, 2'b01, 0, 32'h42, 32'hAAAA1234, 32'h0, 0, 5, 3, 1, 32'h10, 32'h12345CA1);
        run_req("ldw_40c", 0, 2'b10, 0, 32'h40, 32'h0, 32'h12345CA1, 0, 4, 3, 0, 32'h10, 32'h0);
        run_req("stw_44",  1, 2'b10, 0, 32'h44, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'h11, 32'hDEADBEEF);
        run_req("ldw_44",  0, 2'b10, 0, 32'h44, 32'h0, 32'hDEADBEEF, 0, 4, 3, 0, 32'h11, 32'h0);
        run_req("err_w42", 0, 2'b10, 0, 32'h42, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0);
        run_req("err_sz3", 0, 2'b11, 0, 32'h40, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0);
        run_req("err_sh41", 1, 2'b01, 0, 32'h41, 32'h5555, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0);

        // Byte store abandoned by reset while reading.
        wr_before = wr_total;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'h40;
        req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw_rst in_read", 32'(MemRead), 32'd1);
        rst = 1'b1;
        #1;
        chk("rmw_rst MemRead", 32'(MemRead), 32'd0);
        chk("rmw_rst MemWrite", 32'(MemWrite), 32'd0);
        chk("rmw_rst req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmw_rst ready_after", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("rmw_rst no_write", wr_total, wr_before);
        chk("rmw_rst word_unchanged", mem[16], 32'h12345CA1);

        run_req("ldw_post", 0, 2'b10, 0, 32'h40, 32'h0, 32'h12345CA1, 0, 4, 3, 0, 32'h10, 32'h0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
